// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
//   - FSM state encoding
//   - funct3 opcodes of the supported M-extension operations
//   - loop length and counter width
//   - small sign helper used when forming results
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
//   mode    : MODE_MUL = shift-add, MODE_DIV = restoring subtract
//   acc     : 64-bit product accumulator
//   prem    : partial remainder (always < divisor, so 32 bits suffice)
//   opa     : shift register; multiplier (MSB first) or dividend/quotient
//   opb     : multiplicand or divisor magnitude
//   *_nx    : next values of acc, prem and opa
module muldiv_step
  import muldiv_pkg::*;
(
  input  mode_t            mode,
  input  logic [63:0]      acc,
  input  logic [XLEN-1:0]  prem,
  input  logic [XLEN-1:0]  opa,
  input  logic [XLEN-1:0]  opb,
  output logic [63:0]      acc_nx,
  output logic [XLEN-1:0]  prem_nx,
  output logic [XLEN-1:0]  opa_nx
);

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] sub;

  always_comb begin
    // 33-bit trial remainder: previous remainder with the next dividend bit.
    shifted = {prem, opa[XLEN-1]};
    fits    = shifted >= {1'b0, opb};
    // When the divisor fits, the difference is < opb, so the low bits are exact.
    sub     = shifted[XLEN-1:0] - opb;

    acc_nx  = acc;
    prem_nx = prem;
    opa_nx  = {opa[XLEN-2:0], 1'b0};

    if (mode == MODE_MUL) begin
      // Multiplier consumed MSB first, so the accumulator shifts left each step.
      acc_nx = {acc[62:0], 1'b0} + (opa[XLEN-1] ? {32'd0, opb} : 64'd0);
    end else begin
      prem_nx = fits ? sub : shifted[XLEN-1:0];
      opa_nx  = {opa[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M multiply/divide unit.
// Holds the ID/EX register via stall_o while iterating, then pulses valid_o
// for one cycle with the result.
//   clk_i, rst_i (async, active-low)
//   valid_i, funct3_i, rs1_data_i, rs2_data_i, rsd_i : ID/EX operand bundle
//   flush_i  : kill in-flight operation
//   stall_o  : freeze ID/EX and earlier (combinational)
//   valid_o  : one-cycle result strobe
//   result_o, rsd_o : result and destination, held until the next completion
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rsd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rsd_o
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic [4:0]        rsd_q;
  logic              neg_q;
  logic              neg_r;
  logic [63:0]       acc;
  logic [XLEN-1:0]   prem;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;

  logic [63:0]       acc_nx;
  logic [XLEN-1:0]   prem_nx;
  logic [XLEN-1:0]   opa_nx;
  mode_t             mode;

  logic              is_mul, is_sdiv, is_udiv, div_zero, ovf, fast;
  logic [XLEN-1:0]   fast_res, mag1, mag2, busy_res;

  assign mode = (f3 == F3_MUL) ? MODE_MUL : MODE_DIV;

  muldiv_step u_step (
    .mode    (mode),
    .acc     (acc),
    .prem    (prem),
    .opa     (opa),
    .opb     (opb),
    .acc_nx  (acc_nx),
    .prem_nx (prem_nx),
    .opa_nx  (opa_nx)
  );

  // Start-time decode of the incoming bundle, including the fast-path cases.
  always_comb begin
    is_mul   = funct3_i == F3_MUL;
    is_sdiv  = (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    is_udiv  = (funct3_i == F3_DIVU) || (funct3_i == F3_REMU);
    div_zero = (is_sdiv || is_udiv) && (rs2_data_i == '0);
    ovf      = is_sdiv && (rs1_data_i == 32'h8000_0000) && (rs2_data_i == '1);
    fast     = !(is_mul || is_sdiv || is_udiv) || div_zero || ovf;

    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    fast_res = '0;
    if (div_zero)
      fast_res = funct3_i[1] ? rs1_data_i : '1;
    else if (ovf)
      fast_res = funct3_i[1] ? '0 : 32'h8000_0000;

    mag1 = neg_if(rs1_data_i, is_sdiv && rs1_data_i[XLEN-1]);
    mag2 = neg_if(rs2_data_i, is_sdiv && rs2_data_i[XLEN-1]);

    // Result formed from the final iteration's next-state values.
    if (f3 == F3_MUL)
      busy_res = acc_nx[XLEN-1:0];
    else if (f3[1])
      busy_res = neg_if(prem_nx, neg_r);
    else
      busy_res = neg_if(opa_nx, neg_q);
  end

  assign stall_o = !flush_i && (((state == IDLE) && valid_i) || (state == BUSY));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      f3       <= '0;
      rsd_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      prem     <= '0;
      opa      <= '0;
      opb      <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
      rsd_o    <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (valid_i) begin
              f3    <= funct3_i;
              rsd_q <= rsd_i;
              cnt   <= '0;
              acc   <= '0;
              prem  <= '0;
              neg_q <= is_sdiv && (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]);
              neg_r <= is_sdiv && rs1_data_i[XLEN-1];
              opa   <= is_mul ? rs2_data_i : mag1;
              opb   <= is_mul ? rs1_data_i : mag2;
              if (fast) begin
                state    <= DONE;
                valid_o  <= 1'b1;
                result_o <= fast_res;
                rsd_o    <= rsd_i;
              end else begin
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            acc  <= acc_nx;
            prem <= prem_nx;
            opa  <= opa_nx;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_W'(ITERS - 1)) begin
              state    <= DONE;
              valid_o  <= 1'b1;
              result_o <= busy_res;
              rsd_o    <= rsd_q;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases plus random
// operations, compared every cycle against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rsd_i;
  logic        stall_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rsd_o;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rsd_i      (rsd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rsd_o      (rsd_o)
  );

  int          errors = 0;
  int          checks = 0;
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_valid;
  logic [31:0] exp_result;
  logic [4:0]  exp_rsd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f)
      F3_MUL:  begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      F3_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:  begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      F3_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f == F3_MUL) return 1'b0;
    if (f != F3_DIV && f != F3_DIVU && f != F3_REM && f != F3_REMU) return 1'b1;
    if (b == 0) return 1'b1;
    if ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Every cycle: outputs against the bench's expectation for that cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_o",  32'(stall_o), 32'(exp_stall));
      check("valid_o",  32'(valid_o), 32'(exp_valid));
      check("result_o", result_o, exp_result);
      check("rsd_o",    32'(rsd_o), 32'(exp_rsd));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      rst_i      = 1'b1;
      valid_i    = 1'b0;
      flush_i    = 1'b0;
      funct3_i   = 3'($urandom);
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      exp_stall  = 1'b0;
      exp_valid  = 1'b0;
    end
  endtask

  // Present one instruction from cycle 0 until completion; optional flush
  // or reset in a given cycle (-1 = none).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int flush_at, input int rst_at);
    int lat;
    lat = is_fast(f, a, b) ? 1 : 33;
    for (int c = 0; c <= lat; c++) begin
      next_cycle();
      valid_i    = 1'b1;
      funct3_i   = f;
      rs1_data_i = a;
      rs2_data_i = b;
      rsd_i      = rd;
      if (c == rst_at) begin
        rst_i      = 1'b0;
        flush_i    = 1'b0;
        exp_stall  = 1'b1;
        exp_valid  = 1'b0;
        exp_result = 32'd0;
        exp_rsd    = 5'd0;
        return;
      end
      rst_i = 1'b1;
      if (c == lat) begin
        flush_i    = 1'b0;
        exp_stall  = 1'b0;
        exp_valid  = 1'b1;
        exp_result = model(f, a, b);
        exp_rsd    = rd;
      end else begin
        flush_i   = (c == flush_at);
        exp_stall = (c != flush_at);
        exp_valid = 1'b0;
        if (c == flush_at) return;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0; rsd_i = 5'd0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_result = 32'd0; exp_rsd = 5'd0;
    #2 rst_i = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Hand-computed values pinning the model.
    check("model_mul_7x6",   model(F3_MUL,  32'd7, 32'd6), 32'd42);
    check("model_div_m7_2",  model(F3_DIV,  32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem_m7_2",  model(F3_REM,  32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_divu_z",    model(F3_DIVU, 32'd100, 32'd0), 32'hFFFF_FFFF);
    check("model_remu_z",    model(F3_REMU, 32'd100, 32'd0), 32'd100);
    check("model_div_ovf",   model(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_rem_ovf",   model(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    check("model_mul_wrap",  model(F3_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'd1);

    // Directed cases.
    run_op(F3_MUL,  32'd7, 32'd6, 5'd5, -1, -1);
    run_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, -1, -1);
    run_op(F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, -1, -1);
    idle(1);
    run_op(F3_DIVU, 32'd100, 32'd0, 5'd8, -1, -1);
    run_op(F3_REMU, 32'd100, 32'd0, 5'd9, -1, -1);
    run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, -1, -1);
    run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, -1, -1);
    run_op(F3_DIVU, 32'd1000, 32'd3, 5'd12, 10, -1);
    run_op(F3_MUL,  32'd3, 32'd5, 5'd13, -1, -1);
    run_op(3'b011,  32'd55, 32'd66, 5'd14, -1, -1);
    run_op(F3_REMU, 32'd77, 32'd5, 5'd15, 0, -1);
    run_op(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd16, -1, -1);
    run_op(F3_DIV,  32'd1000, 32'hFFFF_FFF9, 5'd17, -1, 20);
    run_op(F3_DIV,  32'd1000, 32'hFFFF_FFF9, 5'd18, -1, -1);

    // Random operations with occasional gaps and flushes.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f;
      int fl;
      case ($urandom_range(0, 10))
        0, 1:    f = F3_MUL;
        2, 3:    f = F3_DIV;
        4, 5:    f = F3_DIVU;
        6, 7:    f = F3_REM;
        8, 9:    f = F3_REMU;
        default: f = 3'($urandom_range(1, 3));
      endcase
      fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 32)) : -1;
      run_op(f, pick_operand(), pick_operand(), 5'($urandom), fl, -1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes the decoded operand bundle presented by the ID/EX pipeline register. While it works, it holds that register, and everything upstream, frozen through a stall output. When done, it delivers a single-cycle result pulse toward the EX/MEM register. It is the consumer end of the ID/EX interface for multi-cycle M-extension operations.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- ITERS, 32, iteration count of the shift-add / restoring-divide loop; equals XLEN.

- clk_i  in  1  single clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  ID/EX holds an M-type instruction.
- funct3_i  in  3  000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are unsupported.
- rs1_data_i  in  32  dividend or multiplicand.
- rs2_data_i  in  32  divisor or multiplier.
- rsd_i  in  5  destination register.
- flush_i  in  1  kill the in-flight operation (branch or exception flush).
- stall_o  out  1  freeze ID/EX and earlier stages.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  32  result; held until the next completion.
- rsd_o  out  5  destination captured at start; held with result_o.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - valid_i=1 and flush_i=0: capture funct3, operands and rsd.
  - Special case (see below): go to DONE.
  - Otherwise: clear the counter and go to BUSY.
- **BUSY**
  - One iteration per cycle.
  - The counter increments 0..ITERS-1.
  - After the iteration with counter=ITERS-1, go to DONE.
- **DONE**
  - valid_o=1; result_o and rsd_o update on entry.
  - Always return to IDLE.
  - valid_i is ignored in DONE, because the same instruction is still visible from ID/EX.
- flush_i=1 in any state forces IDLE on the next edge with no valid_o. It has priority over valid_i.
- stall_o = ~flush_i & ((IDLE & valid_i) | BUSY). It is combinational, so ID/EX freezes in the cycle the instruction first appears.
- **MUL**
  - Shift-add over the 32 multiplier bits.
  - Accumulator is 64 bits; result is the low 32 bits.
  - Sign-agnostic.
- **DIV/REM (signed)**
  - Take the magnitudes of both operands and run unsigned restoring division.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
- **DIVU/REMU**
  - Unsigned restoring division.
  - Each step carries a 33-bit partial remainder.
- **Fast path:** IDLE to DONE directly, with no BUSY cycles.
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Unsupported funct3: result 0.

## Timing
- Reset (rst_i low, any state, asynchronous):
  - State goes to IDLE.
  - valid_o, result_o, rsd_o, the counter and all datapath registers go to 0.
  - stall_o follows its combinational equation.
- Normal operation, with cycle 0 being the first cycle valid_i is high in IDLE:
  - stall_o is high in cycles 0..32.
  - BUSY occupies cycles 1..32.
  - valid_o is high in cycle 33 and stall_o is low.
  - ID/EX loads the next instruction at the end of cycle 33.
  - The earliest next start is cycle 34.
- Fast path: stall_o is high in cycle 0 and valid_o is high in cycle 1.
- flush_i in cycle k:
  - stall_o is low in cycle k.
  - The state is IDLE in cycle k+1.
  - result_o and rsd_o keep their previous values.
- rst_i deasserting mid-cycle has no special effect; the next posedge is a normal IDLE evaluation.

## Structure
- Shared package `muldiv_pkg` holds:
  - the state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the funct3 constants F3_MUL, F3_DIV, F3_DIVU, F3_REM, F3_REMU;
  - ITERS.
- Sub-module `muldiv_step` is the combinational single-iteration datapath, covering both shift-add and restore-subtract.
  - Inputs: mode, accumulator, partial remainder, operand.
  - Outputs: the next values of those registers.
  - The top-level module keeps the FSM, the counter, sign handling and the fast path.

## Test plan
- MUL 7 × 6:
  - stall_o high for cycles 0..32.
  - valid_o in cycle 33 with result_o=42 and rsd_o as captured.
- Signed division of -7 (0xFFFFFFF9) by 2:
  - DIV gives 0xFFFFFFFD.
  - A separate REM gives 0xFFFFFFFF.
  - Both strobe valid_o in cycle 33.
- Divide by zero, rs1=100, rs2=0:
  - DIVU gives 0xFFFFFFFF.
  - REMU gives 100.
  - valid_o in cycle 1.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF:
  - DIV gives 0x80000000.
  - REM gives 0.
  - Both take the fast path.
- Flush during a DIVU, flush_i pulsed in cycle 10:
  - No valid_o and stall_o low in cycle 10.
  - A MUL 3 × 5 presented in cycle 11 completes in cycle 44 with 15.
- Reset during BUSY, rst_i low in cycle 20:
  - Outputs go to zero immediately and the state is IDLE.
  - With valid_i=1 after release, stall_o asserts and a full operation completes correctly.
